// File: rtl/mem_axi_pkg.sv
// Shared definitions for the AXI4 dual-port RAM front-end.
// Contents: clogb2 helper, burst/response encodings, FSM state types and
// the burst legality check used by the address generators.
package mem_axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_e;
  typedef enum logic       {R_IDLE, R_BURST}        rstate_e;

  // ceil(log2(value)); clogb2(1) = 0
  function automatic int clogb2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Reserved burst type, or WRAP with a length other than 2/4/8/16 beats.
  function automatic logic burst_illegal(input logic [7:0] len, input logic [1:0] burst);
    logic wrap_ok;
    wrap_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    return (burst == BURST_RSVD) || ((burst == BURST_WRAP) && !wrap_ok);
  endfunction

endpackage

// File: rtl/mem_axi_dpram_ctrl_if.sv
// AXI4 bus bundle (no ID, full-width beats) between a master and the
// dual-port RAM controller.
// Channels: AW (addr/len/burst), W (data/strb/last), B (resp),
//           AR (addr/len/burst), R (data/resp/last).
// Modports: master drives requests, slave drives READY/response signals.
interface mem_axi_dpram_ctrl_if #(
  parameter int WIDTH_AD = 10,
  parameter int WIDTH_DA = 32,
  parameter int WIDTH_DS = WIDTH_DA / 8
);
  logic [WIDTH_AD-1:0] AWADDR;
  logic [7:0]          AWLEN;
  logic [1:0]          AWBURST;
  logic                AWVALID;
  logic                AWREADY;
  logic [WIDTH_DA-1:0] WDATA;
  logic [WIDTH_DS-1:0] WSTRB;
  logic                WLAST;
  logic                WVALID;
  logic                WREADY;
  logic [1:0]          BRESP;
  logic                BVALID;
  logic                BREADY;
  logic [WIDTH_AD-1:0] ARADDR;
  logic [7:0]          ARLEN;
  logic [1:0]          ARBURST;
  logic                ARVALID;
  logic                ARREADY;
  logic [WIDTH_DA-1:0] RDATA;
  logic [1:0]          RRESP;
  logic                RLAST;
  logic                RVALID;
  logic                RREADY;

  modport master (
    output AWADDR, AWLEN, AWBURST, AWVALID, input AWREADY,
    output WDATA, WSTRB, WLAST, WVALID, input WREADY,
    input BRESP, BVALID, output BREADY,
    output ARADDR, ARLEN, ARBURST, ARVALID, input ARREADY,
    input RDATA, RRESP, RLAST, RVALID, output RREADY
  );

  modport slave (
    input AWADDR, AWLEN, AWBURST, AWVALID, output AWREADY,
    input WDATA, WSTRB, WLAST, WVALID, output WREADY,
    output BRESP, BVALID, input BREADY,
    input ARADDR, ARLEN, ARBURST, ARVALID, output ARREADY,
    output RDATA, RRESP, RLAST, RVALID, input RREADY
  );
endinterface

// File: rtl/axi_burst_addr_gen.sv
// Next-beat address for an AXI burst (combinational).
// Ports: addr_i current beat address, len_i beats-1, burst_i burst type,
//        next_addr_o following beat address (lane bits zero),
//        illegal_o burst type/length combination is not allowed.
// Illegal WRAP lengths and the reserved type step like INCR.
module axi_burst_addr_gen
  import mem_axi_pkg::*;
#(
  parameter int WIDTH_AD = 10,
  parameter int WIDTH_DS = 4
) (
  input  logic [WIDTH_AD-1:0] addr_i,
  input  logic [7:0]          len_i,
  input  logic [1:0]          burst_i,
  output logic [WIDTH_AD-1:0] next_addr_o,
  output logic                illegal_o
);
  localparam int WIDTH_DSB = clogb2(WIDTH_DS);
  localparam logic [WIDTH_AD-1:0] STEP      = WIDTH_AD'(WIDTH_DS);
  localparam logic [WIDTH_AD-1:0] LANE_MASK = WIDTH_AD'((1 << WIDTH_DSB) - 1);

  logic [WIDTH_AD-1:0] base_addr;
  logic [WIDTH_AD-1:0] incr_addr;
  logic [WIDTH_AD-1:0] wrap_mask;

  always_comb begin
    illegal_o = burst_illegal(len_i, burst_i);
    base_addr = addr_i & ~LANE_MASK;
    incr_addr = base_addr + STEP;
    // For legal lengths len+1 is a power of two, so the window mask is
    // simply len followed by the lane bits set.
    wrap_mask = (WIDTH_AD'(len_i) << WIDTH_DSB) | LANE_MASK;
    case (burst_i)
      BURST_FIXED: next_addr_o = base_addr;
      BURST_INCR:  next_addr_o = incr_addr;
      BURST_WRAP:  next_addr_o = illegal_o ? incr_addr
                                           : ((base_addr & ~wrap_mask) | (incr_addr & wrap_mask));
      default:     next_addr_o = incr_addr;
    endcase
  end
endmodule

// File: rtl/mem_axi_dpram_ctrl.sv
// AXI4 slave front-end for a byte-strobed simple dual-port synchronous RAM.
// Ports: CLK, RESETn (async, active-low); axi slave bundle;
//        M_WADDR/M_WDATA/M_WSTRB/M_WEN RAM write port;
//        M_RADDR/M_RSTRB/M_REN RAM read port, M_RDATA read data (valid the
//        cycle after M_REN, held by the RAM while M_REN is low).
//
// Write FSM
//   state  | meaning
//   W_IDLE | AWREADY=1, waiting for a write burst
//   W_DATA | WREADY=1, one RAM write per W beat, beat counter ends burst
//   W_RESP | BVALID=1 until BREADY
// Read FSM
//   state   | meaning
//   R_IDLE  | ARREADY=1, waiting for a read burst
//   R_BURST | issuing RAM reads and returning beats until the last pop
module mem_axi_dpram_ctrl
  import mem_axi_pkg::*;
#(
  parameter int WIDTH_AD  = 10,
  parameter int WIDTH_DA  = 32,
  parameter int WIDTH_DS  = WIDTH_DA / 8,
  parameter int WIDTH_DSB = clogb2(WIDTH_DS)
) (
  input  logic                CLK,
  input  logic                RESETn,
  mem_axi_dpram_ctrl_if.slave axi,
  output logic [WIDTH_AD-1:0] M_WADDR,
  output logic [WIDTH_DA-1:0] M_WDATA,
  output logic [WIDTH_DS-1:0] M_WSTRB,
  output logic                M_WEN,
  output logic [WIDTH_AD-1:0] M_RADDR,
  input  logic [WIDTH_DA-1:0] M_RDATA,
  output logic [WIDTH_DS-1:0] M_RSTRB,
  output logic                M_REN
);
  localparam logic [WIDTH_AD-1:0] LANE_MASK = WIDTH_AD'((1 << WIDTH_DSB) - 1);

  // ---------------- write channel ----------------
  wstate_e             wstate_q, wstate_d;
  logic [WIDTH_AD-1:0] waddr_q, waddr_d, w_next;
  logic [7:0]          wlen_q, wlen_d, wcnt_q, wcnt_d;
  logic [1:0]          wburst_q, wburst_d;
  logic                werr_q, werr_d, w_illegal, w_last;
  logic                aw_ready, w_ready, b_valid;

  axi_burst_addr_gen #(.WIDTH_AD(WIDTH_AD), .WIDTH_DS(WIDTH_DS)) u_wgen (
    .addr_i(waddr_q), .len_i(wlen_q), .burst_i(wburst_q),
    .next_addr_o(w_next), .illegal_o(w_illegal)
  );

  always_comb begin
    wstate_d = wstate_q;
    waddr_d  = waddr_q;
    wlen_d   = wlen_q;
    wburst_d = wburst_q;
    wcnt_d   = wcnt_q;
    werr_d   = werr_q;
    aw_ready = 1'b0;
    w_ready  = 1'b0;
    b_valid  = 1'b0;
    w_last   = (wcnt_q == 8'd0);
    case (wstate_q)
      W_IDLE: begin
        aw_ready = 1'b1;
        if (axi.AWVALID) begin
          wstate_d = W_DATA;
          waddr_d  = axi.AWADDR & ~LANE_MASK;
          wlen_d   = axi.AWLEN;
          wburst_d = axi.AWBURST;
          wcnt_d   = axi.AWLEN;
          werr_d   = 1'b0;
        end
      end
      W_DATA: begin
        w_ready = 1'b1;
        if (axi.WVALID) begin
          waddr_d = w_next;
          if (w_illegal || (axi.WLAST != w_last)) werr_d = 1'b1;
          if (w_last) wstate_d = W_RESP;
          else        wcnt_d   = wcnt_q - 8'd1;
        end
      end
      W_RESP: begin
        b_valid = 1'b1;
        if (axi.BREADY) wstate_d = W_IDLE;
      end
      default: wstate_d = W_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      wstate_q <= W_IDLE;
      waddr_q  <= '0;
      wlen_q   <= '0;
      wburst_q <= '0;
      wcnt_q   <= '0;
      werr_q   <= 1'b0;
    end else begin
      wstate_q <= wstate_d;
      waddr_q  <= waddr_d;
      wlen_q   <= wlen_d;
      wburst_q <= wburst_d;
      wcnt_q   <= wcnt_d;
      werr_q   <= werr_d;
    end
  end

  assign axi.AWREADY = aw_ready;
  assign axi.WREADY  = w_ready;
  assign axi.BVALID  = b_valid;
  assign axi.BRESP   = (b_valid && werr_q) ? RESP_SLVERR : RESP_OKAY;
  assign M_WADDR     = waddr_q;
  assign M_WDATA     = axi.WDATA;
  assign M_WSTRB     = axi.WSTRB;
  assign M_WEN       = axi.WVALID & w_ready;

  // ---------------- read channel ----------------
  rstate_e             rstate_q, rstate_d;
  logic [WIDTH_AD-1:0] raddr_q, raddr_d, r_next;
  logic [7:0]          rlen_q, rlen_d, rpop_q, rpop_d;
  logic [1:0]          rburst_q, rburst_d;
  logic [8:0]          rissue_q, rissue_d;
  logic [1:0]          rout_q, rout_d, r_out_after;
  logic                mvld_q, mvld_d, skid_full_q, skid_full_d;
  logic [WIDTH_DA-1:0] skid_q, skid_d;
  logic                rerr_q, rerr_d, r_illegal;
  logic                r_valid, r_pop, r_ren;

  axi_burst_addr_gen #(.WIDTH_AD(WIDTH_AD), .WIDTH_DS(WIDTH_DS)) u_rgen (
    .addr_i(raddr_q), .len_i(rlen_q), .burst_i(rburst_q),
    .next_addr_o(r_next), .illegal_o(r_illegal)
  );

  // mvld_q: M_RDATA carries a beat that is neither popped nor in the skid.
  // rout_q: beats issued to the RAM and not yet popped (skid + M_RDATA).
  always_comb begin
    rstate_d    = rstate_q;
    raddr_d     = raddr_q;
    rlen_d      = rlen_q;
    rburst_d    = rburst_q;
    rissue_d    = rissue_q;
    rpop_d      = rpop_q;
    rerr_d      = rerr_q;
    skid_full_d = skid_full_q;
    skid_d      = skid_q;

    r_valid     = skid_full_q | mvld_q;
    r_pop       = r_valid & axi.RREADY;
    r_out_after = rout_q - {1'b0, r_pop};
    r_ren       = (rstate_q == R_BURST) && (rissue_q != 9'd0) && (r_out_after < 2'd2);

    if (rstate_q == R_IDLE) begin
      if (axi.ARVALID) begin
        rstate_d = R_BURST;
        raddr_d  = axi.ARADDR & ~LANE_MASK;
        rlen_d   = axi.ARLEN;
        rburst_d = axi.ARBURST;
        rissue_d = {1'b0, axi.ARLEN} + 9'd1;
        rpop_d   = axi.ARLEN;
        rerr_d   = 1'b0;
      end
    end else begin
      if (r_illegal) rerr_d = 1'b1;
      if (r_ren) begin
        raddr_d  = r_next;
        rissue_d = rissue_q - 9'd1;
      end
      if (r_pop) begin
        if (rpop_q == 8'd0) rstate_d = R_IDLE;
        else                rpop_d   = rpop_q - 8'd1;
      end
    end

    rout_d = r_out_after + {1'b0, r_ren};
    // With the skid full and no pop, no read is issued, so the RAM keeps
    // the pending beat on M_RDATA until the skid frees up.
    mvld_d = r_ren | (mvld_q & skid_full_q & ~r_pop);
    if (skid_full_q) begin
      if (r_pop) begin
        skid_full_d = mvld_q;
        skid_d      = M_RDATA;
      end
    end else if (mvld_q && !r_pop) begin
      skid_full_d = 1'b1;
      skid_d      = M_RDATA;
    end
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      rstate_q    <= R_IDLE;
      raddr_q     <= '0;
      rlen_q      <= '0;
      rburst_q    <= '0;
      rissue_q    <= '0;
      rpop_q      <= '0;
      rout_q      <= '0;
      mvld_q      <= 1'b0;
      skid_full_q <= 1'b0;
      skid_q      <= '0;
      rerr_q      <= 1'b0;
    end else begin
      rstate_q    <= rstate_d;
      raddr_q     <= raddr_d;
      rlen_q      <= rlen_d;
      rburst_q    <= rburst_d;
      rissue_q    <= rissue_d;
      rpop_q      <= rpop_d;
      rout_q      <= rout_d;
      mvld_q      <= mvld_d;
      skid_full_q <= skid_full_d;
      skid_q      <= skid_d;
      rerr_q      <= rerr_d;
    end
  end

  assign axi.ARREADY = (rstate_q == R_IDLE);
  assign axi.RVALID  = r_valid;
  assign axi.RDATA   = skid_full_q ? skid_q : (mvld_q ? M_RDATA : '0);
  assign axi.RLAST   = r_valid && (rpop_q == 8'd0);
  assign axi.RRESP   = (r_valid && rerr_q) ? RESP_SLVERR : RESP_OKAY;
  assign M_RADDR     = raddr_q;
  assign M_RSTRB     = '1;
  assign M_REN       = r_ren;
endmodule

// File: tb/tb_mem_axi_dpram_ctrl.sv
module tb_mem_axi_dpram_ctrl;
  logic        clk;
  logic        rst_n;
  logic [9:0]  m_waddr, m_raddr;
  logic [31:0] m_wdata, m_rdata;
  logic [3:0]  m_wstrb, m_rstrb;
  logic        m_wen, m_ren;

  int checks = 0;
  int failures = 0;

  mem_axi_dpram_ctrl_if #(.WIDTH_AD(10), .WIDTH_DA(32)) axi ();

  mem_axi_dpram_ctrl #(.WIDTH_AD(10), .WIDTH_DA(32)) dut (
    .CLK(clk), .RESETn(rst_n), .axi(axi),
    .M_WADDR(m_waddr), .M_WDATA(m_wdata), .M_WSTRB(m_wstrb), .M_WEN(m_wen),
    .M_RADDR(m_raddr), .M_RDATA(m_rdata), .M_RSTRB(m_rstrb), .M_REN(m_ren)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: byte-strobed writes, registered read that holds while idle,
  // same-address collision returns the new data.
  logic [31:0] ram [0:255];

  function automatic logic [31:0] ram_read(input logic [9:0] ra);
    logic [31:0] w;
    w = ram[ra[9:2]];
    if (m_wen && m_waddr == ra)
      for (int b = 0; b < 4; b++) if (m_wstrb[b]) w[b*8 +: 8] = m_wdata[b*8 +: 8];
    return w;
  endfunction

  always @(posedge clk) begin
    if (m_wen)
      for (int b = 0; b < 4; b++)
        if (m_wstrb[b]) ram[m_waddr[9:2]][b*8 +: 8] <= m_wdata[b*8 +: 8];
    if (m_ren) m_rdata <= ram_read(m_raddr);
  end

  logic [31:0] wd [16];
  logic [3:0]  ws [16];
  logic [9:0]  cap_waddr [16];
  logic        wr_timeout;
  logic [9:0]  cap_raddr [16];
  logic [31:0] cap_rdata [16];
  logic        cap_rlast [16];
  logic [1:0]  cap_rresp [16];
  int          n_ren, n_beats, first_rv, first_ren, last_pop;
  logic        rd_timeout, extra_rvalid;

  task automatic do_write(input logic [9:0] addr, input logic [7:0] len, input logic [1:0] burst,
                          input int early, output logic [1:0] bresp);
    int beat;
    int guard;
    bresp = 2'bxx;
    @(negedge clk);
    axi.AWADDR = addr; axi.AWLEN = len; axi.AWBURST = burst; axi.AWVALID = 1'b1;
    #1;
    guard = 0;
    while (!axi.AWREADY && guard < 20) begin @(negedge clk); #1; guard++; end
    beat = 0;
    while (beat <= int'(len) && guard < 200) begin
      @(negedge clk);
      axi.AWVALID = 1'b0;
      axi.WVALID = 1'b1; axi.WDATA = wd[beat]; axi.WSTRB = ws[beat];
      axi.WLAST = (beat == int'(len)) || (beat == early);
      #1;
      if (axi.WREADY) begin cap_waddr[beat] = m_waddr; beat++; end
      guard++;
    end
    @(negedge clk);
    axi.AWVALID = 1'b0; axi.WVALID = 1'b0; axi.WLAST = 1'b0; axi.BREADY = 1'b1;
    #1;
    while (!axi.BVALID && guard < 220) begin @(negedge clk); #1; guard++; end
    wr_timeout = (guard >= 200);
    bresp = axi.BRESP;
    @(negedge clk);
    axi.BREADY = 1'b0;
  endtask

  task automatic do_read(input logic [9:0] addr, input logic [7:0] len, input logic [1:0] burst,
                         input bit toggle);
    int idx;
    int guard;
    n_ren = 0; n_beats = 0; first_rv = -1; first_ren = -1; last_pop = -1;
    @(negedge clk);
    axi.ARADDR = addr; axi.ARLEN = len; axi.ARBURST = burst; axi.ARVALID = 1'b1;
    #1;
    guard = 0;
    while (!axi.ARREADY && guard < 20) begin @(negedge clk); #1; guard++; end
    idx = 0;
    while (n_beats <= int'(len) && idx < 200) begin
      @(negedge clk);
      axi.ARVALID = 1'b0;
      axi.RREADY = toggle ? (idx % 2 == 0) : 1'b1;
      #1;
      if (m_ren) begin
        if (first_ren < 0) first_ren = idx;
        if (n_ren < 16) cap_raddr[n_ren] = m_raddr;
        n_ren++;
      end
      if (axi.RVALID && first_rv < 0) first_rv = idx;
      if (axi.RVALID && axi.RREADY) begin
        if (n_beats < 16) begin
          cap_rdata[n_beats] = axi.RDATA;
          cap_rlast[n_beats] = axi.RLAST;
          cap_rresp[n_beats] = axi.RRESP;
        end
        n_beats++;
        last_pop = idx;
      end
      idx++;
    end
    rd_timeout = (n_beats <= int'(len)) || (guard >= 20);
    @(negedge clk);
    axi.RREADY = 1'b0;
    #1;
    extra_rvalid = axi.RVALID;
  endtask

  task automatic test_reset;
    logic [7:0] st;
    @(negedge clk); #1;
    st = {axi.AWREADY, axi.ARREADY, axi.WREADY, axi.BVALID, axi.RVALID, axi.RLAST, m_ren, m_wen};
    checks++;
    if (st !== 8'b1100_0000) begin
      failures++; $display("FAIL reset_in: got %b expected 11000000", st);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); #1;
    st = {axi.AWREADY, axi.ARREADY, axi.WREADY, axi.BVALID, axi.RVALID, axi.RLAST, m_ren, m_wen};
    checks++;
    if (st !== 8'b1100_0000) begin
      failures++; $display("FAIL reset_after: got %b expected 11000000", st);
    end
  endtask

  task automatic test_single;
    logic [1:0] br;
    wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
    do_write(10'h010, 8'd0, 2'b01, -1, br);
    checks++;
    if (wr_timeout !== 1'b0 || br !== 2'b00) begin
      failures++; $display("FAIL single_bresp: got %b to=%b expected 00", br, wr_timeout);
    end
    do_read(10'h010, 8'd0, 2'b01, 1'b0);
    checks++;
    if (rd_timeout !== 1'b0 || cap_rdata[0] !== 32'hDEADBEEF) begin
      failures++; $display("FAIL single_rdata: got %h expected deadbeef", cap_rdata[0]);
    end
    checks++;
    if (cap_rlast[0] !== 1'b1 || cap_rresp[0] !== 2'b00) begin
      failures++; $display("FAIL single_rlast_rresp: got %b/%b expected 1/00", cap_rlast[0], cap_rresp[0]);
    end
    checks++;
    if (first_ren !== 0 || first_rv !== 1) begin
      failures++; $display("FAIL single_latency: got ren@%0d rvalid@%0d expected 0/1", first_ren, first_rv);
    end
  endtask

  task automatic test_strobe;
    logic [1:0] br;
    wd[0] = 32'hFFFFFFFF; ws[0] = 4'hF;
    do_write(10'h020, 8'd0, 2'b01, -1, br);
    wd[0] = 32'h11223344; ws[0] = 4'b0101;
    do_write(10'h020, 8'd0, 2'b01, -1, br);
    do_read(10'h020, 8'd0, 2'b01, 1'b0);
    checks++;
    if (rd_timeout !== 1'b0 || cap_rdata[0] !== 32'hFF22FF44) begin
      failures++; $display("FAIL strobe_rdata: got %h expected ff22ff44", cap_rdata[0]);
    end
  endtask

  task automatic test_incr_wrap_addr;
    logic [1:0] br;
    logic [9:0] ea [4];
    ea = '{10'h3F8, 10'h3FC, 10'h000, 10'h004};
    for (int i = 0; i < 4; i++) begin wd[i] = 32'hA000_0000 + i; ws[i] = 4'hF; end
    do_write(10'h3F8, 8'd3, 2'b01, -1, br);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (cap_waddr[i] !== ea[i]) begin
        failures++; $display("FAIL incr_waddr[%0d]: got %h expected %h", i, cap_waddr[i], ea[i]);
      end
    end
    do_read(10'h3F8, 8'd3, 2'b01, 1'b0);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rd_timeout !== 1'b0 || cap_rdata[i] !== 32'hA000_0000 + i) begin
        failures++; $display("FAIL incr_rdata[%0d]: got %h expected %h", i, cap_rdata[i], 32'hA000_0000 + i);
      end
    end
  endtask

  task automatic test_wrap_read;
    logic [9:0] ea [4];
    ea = '{10'h008, 10'h00C, 10'h000, 10'h004};
    do_read(10'h008, 8'd3, 2'b10, 1'b0);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (n_ren !== 4 || cap_raddr[i] !== ea[i]) begin
        failures++; $display("FAIL wrap_raddr[%0d]: got %h (n=%0d) expected %h", i, cap_raddr[i], n_ren, ea[i]);
      end
    end
    checks++;
    if (cap_rdata[2] !== 32'hA000_0002 || cap_rdata[3] !== 32'hA000_0003 || cap_rresp[0] !== 2'b00) begin
      failures++; $display("FAIL wrap_rdata: got %h %h resp %b expected a0000002 a0000003 00",
                           cap_rdata[2], cap_rdata[3], cap_rresp[0]);
    end
  endtask

  task automatic test_read_len7(input bit toggle);
    logic [1:0] br;
    int bad;
    for (int i = 0; i < 8; i++) begin wd[i] = 32'h5500_0000 + (i * 32'h11); ws[i] = 4'hF; end
    if (!toggle) do_write(10'h100, 8'd7, 2'b01, -1, br);
    do_read(10'h100, 8'd7, 2'b01, toggle);
    bad = 0;
    for (int i = 0; i < 8; i++)
      if (cap_rdata[i] !== wd[i] || cap_rlast[i] !== (i == 7)) bad++;
    checks++;
    if (rd_timeout !== 1'b0 || n_beats !== 8 || bad !== 0 || extra_rvalid !== 1'b0) begin
      failures++; $display("FAIL len7_beats(toggle=%0d): got beats=%0d bad=%0d extra=%b expected 8/0/0",
                           toggle, n_beats, bad, extra_rvalid);
    end
    if (!toggle) begin
      checks++;
      if (last_pop - first_rv !== 7) begin
        failures++; $display("FAIL len7_stream: got span %0d expected 7", last_pop - first_rv);
      end
    end
  endtask

  task automatic test_errors;
    logic [1:0] br;
    logic [9:0] ea [3];
    wd[0] = 32'h0BAD_0BAD; ws[0] = 4'hF;
    do_write(10'h040, 8'd0, 2'b11, -1, br);
    checks++;
    if (wr_timeout !== 1'b0 || br !== 2'b10) begin
      failures++; $display("FAIL rsvd_bresp: got %b expected 10", br);
    end
    for (int i = 0; i < 4; i++) begin wd[i] = 32'hC0DE_0000 + i; ws[i] = 4'hF; end
    do_write(10'h200, 8'd3, 2'b01, 1, br);
    checks++;
    if (wr_timeout !== 1'b0 || br !== 2'b10) begin
      failures++; $display("FAIL early_wlast_bresp: got %b to=%b expected 10", br, wr_timeout);
    end
    do_write(10'h200, 8'd0, 2'b01, -1, br);
    checks++;
    if (br !== 2'b00) begin
      failures++; $display("FAIL okay_after_err: got %b expected 00", br);
    end
    ea = '{10'h3F8, 10'h3FC, 10'h000};
    do_read(10'h3F8, 8'd2, 2'b10, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rd_timeout !== 1'b0 || cap_raddr[i] !== ea[i] || cap_rresp[i] !== 2'b10) begin
        failures++; $display("FAIL badwrap[%0d]: got addr %h resp %b expected %h 10",
                             i, cap_raddr[i], cap_rresp[i], ea[i]);
      end
    end
  endtask

  task automatic test_reset_midread;
    int guard;
    @(negedge clk);
    axi.ARADDR = 10'h100; axi.ARLEN = 8'd7; axi.ARBURST = 2'b01; axi.ARVALID = 1'b1;
    #1;
    guard = 0;
    while (!axi.ARREADY && guard < 20) begin @(negedge clk); #1; guard++; end
    @(negedge clk); axi.ARVALID = 1'b0; axi.RREADY = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (axi.RVALID !== 1'b1 || axi.ARREADY !== 1'b0) begin
      failures++; $display("FAIL midread_busy: got rvalid=%b arready=%b expected 1/0", axi.RVALID, axi.ARREADY);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (axi.RVALID !== 1'b0 || axi.ARREADY !== 1'b1 || m_ren !== 1'b0) begin
      failures++; $display("FAIL midread_reset: got rvalid=%b arready=%b ren=%b expected 0/1/0",
                           axi.RVALID, axi.ARREADY, m_ren);
    end
    @(negedge clk); rst_n = 1'b1;
    do_read(10'h010, 8'd0, 2'b01, 1'b0);
    checks++;
    if (rd_timeout !== 1'b0 || cap_rdata[0] !== 32'hDEADBEEF || cap_rlast[0] !== 1'b1) begin
      failures++; $display("FAIL post_reset_read: got %h last=%b expected deadbeef 1", cap_rdata[0], cap_rlast[0]);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    axi.AWADDR = '0; axi.AWLEN = '0; axi.AWBURST = '0; axi.AWVALID = 1'b0;
    axi.WDATA = '0; axi.WSTRB = '0; axi.WLAST = 1'b0; axi.WVALID = 1'b0; axi.BREADY = 1'b0;
    axi.ARADDR = '0; axi.ARLEN = '0; axi.ARBURST = '0; axi.ARVALID = 1'b0; axi.RREADY = 1'b0;
    test_reset();
    test_single();
    test_strobe();
    test_incr_wrap_addr();
    test_wrap_read();
    test_read_len7(1'b0);
    test_read_len7(1'b1);
    test_errors();
    test_reset_midread();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
